// File: rtl/regfile_pkg.sv
// Shared constants and types for the MIPS register file and its read ports.
// Pure declarations: no logic, no latency, no flow control.
package regfile_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

   localparam reg_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/regfile_read_port.sv
// Combinational 32:1 read mux with address 0 forced to zero; zero latency, no backpressure.
module regfile_read_port
   import regfile_pkg::*;
(
   input  logic [NUM_REGS-1:0][DATA_W-1:0] i_regs,
   input  reg_addr_t                       i_addr,
   output reg_data_t                       o_data
);

   always_comb begin
      o_data = '0;
      if (i_addr != ZERO_REG) begin
         o_data = i_regs[i_addr];
      end
   end

endmodule

// File: rtl/mips_register_file.sv
// 32x32 MIPS register file: 2 async read ports, 1 sync write, no bypass, no backpressure.
// REGFILE_DEBUG_PORTS_EN adds regOut0..regOut31 mirroring each register.
module mips_register_file
   import regfile_pkg::*;
(
   input  logic      Clk,
   input  logic      Rst,
   input  reg_addr_t RA,
   input  reg_addr_t RB,
   input  reg_addr_t RW,
   input  reg_data_t BusW,
   input  logic      RegWr,
   output reg_data_t BusA,
`ifdef REGFILE_DEBUG_PORTS_EN
   output reg_data_t BusB,
   output reg_data_t regOut0,  output reg_data_t regOut1,
   output reg_data_t regOut2,  output reg_data_t regOut3,
   output reg_data_t regOut4,  output reg_data_t regOut5,
   output reg_data_t regOut6,  output reg_data_t regOut7,
   output reg_data_t regOut8,  output reg_data_t regOut9,
   output reg_data_t regOut10, output reg_data_t regOut11,
   output reg_data_t regOut12, output reg_data_t regOut13,
   output reg_data_t regOut14, output reg_data_t regOut15,
   output reg_data_t regOut16, output reg_data_t regOut17,
   output reg_data_t regOut18, output reg_data_t regOut19,
   output reg_data_t regOut20, output reg_data_t regOut21,
   output reg_data_t regOut22, output reg_data_t regOut23,
   output reg_data_t regOut24, output reg_data_t regOut25,
   output reg_data_t regOut26, output reg_data_t regOut27,
   output reg_data_t regOut28, output reg_data_t regOut29,
   output reg_data_t regOut30, output reg_data_t regOut31
`else
   output reg_data_t BusB
`endif
);

   // Register 0 has no storage, so no write address or enable value can disturb it.
   logic [NUM_REGS-1:1][DATA_W-1:0] r_regs;
   logic [NUM_REGS-1:0][DATA_W-1:0] w_regs;

   assign w_regs = {r_regs, DATA_W'(0)};

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_regs <= '0;
      end else if (RegWr && (RW != ZERO_REG)) begin
         r_regs[RW] <= BusW;
      end
   end

   regfile_read_port u_read_a (
      .i_regs (w_regs),
      .i_addr (RA),
      .o_data (BusA)
   );

   regfile_read_port u_read_b (
      .i_regs (w_regs),
      .i_addr (RB),
      .o_data (BusB)
   );

`ifdef REGFILE_DEBUG_PORTS_EN
   assign regOut0  = w_regs[0];   assign regOut1  = w_regs[1];
   assign regOut2  = w_regs[2];   assign regOut3  = w_regs[3];
   assign regOut4  = w_regs[4];   assign regOut5  = w_regs[5];
   assign regOut6  = w_regs[6];   assign regOut7  = w_regs[7];
   assign regOut8  = w_regs[8];   assign regOut9  = w_regs[9];
   assign regOut10 = w_regs[10];  assign regOut11 = w_regs[11];
   assign regOut12 = w_regs[12];  assign regOut13 = w_regs[13];
   assign regOut14 = w_regs[14];  assign regOut15 = w_regs[15];
   assign regOut16 = w_regs[16];  assign regOut17 = w_regs[17];
   assign regOut18 = w_regs[18];  assign regOut19 = w_regs[19];
   assign regOut20 = w_regs[20];  assign regOut21 = w_regs[21];
   assign regOut22 = w_regs[22];  assign regOut23 = w_regs[23];
   assign regOut24 = w_regs[24];  assign regOut25 = w_regs[25];
   assign regOut26 = w_regs[26];  assign regOut27 = w_regs[27];
   assign regOut28 = w_regs[28];  assign regOut29 = w_regs[29];
   assign regOut30 = w_regs[30];  assign regOut31 = w_regs[31];
`endif

endmodule

// File: tb/tb_mips_register_file.sv
// Directed and random self-checking bench for mips_register_file.
module tb_mips_register_file;
   import regfile_pkg::*;

   logic      Clk;
   logic      Rst;
   reg_addr_t RA, RB, RW;
   reg_data_t BusW;
   logic      RegWr;
   reg_data_t BusA, BusB;

   int checks   = 0;
   int failures = 0;

   reg_data_t model [NUM_REGS];

   mips_register_file dut (
      .Clk   (Clk),
      .Rst   (Rst),
      .RA    (RA),
      .RB    (RB),
      .RW    (RW),
      .BusW  (BusW),
      .RegWr (RegWr),
      .BusA  (BusA),
      .BusB  (BusB)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input reg_data_t got, input reg_data_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance through one rising edge; outputs are then sampled 1ns later.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic wr(input reg_addr_t a, input reg_data_t d);
      RW = a; BusW = d; RegWr = 1'b1;
      tick();
      RegWr = 1'b0;
   endtask

   task automatic check_all(input string tag, input reg_data_t exp);
      for (int i = 0; i < NUM_REGS; i++) begin
         RA = reg_addr_t'(i);
         RB = reg_addr_t'(NUM_REGS - 1 - i);
         #1;
         check({tag, "_A"}, BusA, exp);
         check({tag, "_B"}, BusB, exp);
      end
   endtask

   initial begin
      int since_rst;
      logic rst_now;
      Rst = 1'b1; RA = '0; RB = '0; RW = '0; BusW = '0; RegWr = 1'b0;
      tick();
      Rst = 1'b0;
      check_all("reset_init", 32'h0);

      // Fill every register, then a single reset edge must clear all of them.
      for (int i = 1; i < NUM_REGS; i++) wr(reg_addr_t'(i), 32'hDEADBEEF);
      RA = 5'd1; RB = 5'd31; #1;
      check("fill_r1", BusA, 32'hDEADBEEF);
      check("fill_r31", BusB, 32'hDEADBEEF);
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      check_all("reset_clear", 32'h0);

      wr(5'd5, 32'h12345678);
      RA = 5'd5; RB = 5'd5; #1;
      check("basic_A", BusA, 32'h12345678);
      check("basic_B", BusB, 32'h12345678);

      wr(5'd0, 32'hFFFFFFFF);
      RA = 5'd0; RB = 5'd5; #1;
      check("r0_zero", BusA, 32'h0);
      check("r0_other", BusB, 32'h12345678);

      wr(5'd7, 32'hA5A5A5A5);
      RW = 5'd7; BusW = 32'h1; RegWr = 1'b0;
      tick();
      RA = 5'd7; #1;
      check("wen_gate", BusA, 32'hA5A5A5A5);

      // Read-during-write returns the old value until the committing edge.
      wr(5'd3, 32'h11);
      RA = 5'd3; RW = 5'd3; BusW = 32'h22; RegWr = 1'b1; #1;
      check("rdw_before", BusA, 32'h11);
      tick();
      check("rdw_after", BusA, 32'h22);
      Rst = 1'b1; RW = 5'd3; BusW = 32'h33; RegWr = 1'b1;
      tick();
      Rst = 1'b0; RegWr = 1'b0; #1;
      check("rst_prio", BusA, 32'h0);
      RA = 5'd7; RB = 5'd5; #1;
      check("rst_prio_r7", BusA, 32'h0);
      check("rst_prio_r5", BusB, 32'h0);

      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      since_rst = 0;
      for (int c = 0; c < 5000; c++) begin
         RA    = reg_addr_t'($urandom_range(0, 31));
         RB    = reg_addr_t'($urandom_range(0, 31));
         RW    = reg_addr_t'($urandom_range(0, 31));
         BusW  = $urandom;
         RegWr = 1'($urandom_range(0, 1));
         rst_now = (since_rst >= 10) && ($urandom_range(0, 9) == 0);
         Rst   = rst_now;
         #1;
         check("soak_A", BusA, model[RA]);
         check("soak_B", BusB, model[RB]);
         if (rst_now) begin
            for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
            since_rst = 0;
         end else begin
            if (RegWr && RW != 5'd0) model[RW] = BusW;
            since_rst++;
         end
         tick();
      end
      Rst = 1'b0; RegWr = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
